// File: rtl/microwave_timer_ctrl.sv
// microwave_timer_ctrl: mm:ss countdown sequencer between the keypad decoder
// and the 7-seg display. Keypad digits shift in from the right, start/pause/clear
// control a 1 Hz BCD countdown, and the magnetron is enabled only while running.
// Optional feature macro: DONE_BEEP_EN -- when defined, beep is held high for
// BEEP_SECS countdown seconds after the cook finishes; otherwise beep is tied 0.
module microwave_timer_ctrl #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int BEEP_SECS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       digit_valid,
    input  logic [3:0] digit_in,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [3:0] min_D1,
    output logic [3:0] min_D0,
    output logic [3:0] sec_D1,
    output logic [3:0] sec_D0,
    output logic [2:0] state,
    output logic       magnetron_en,
    output logic       done,
    output logic       beep
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ENTRY  = 3'd1,
        ST_RUN    = 3'd2,
        ST_PAUSED = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // A prescaler below 2 cycles or a zero-length beep makes no sense.
    if (TICK_DIV < 2 || BEEP_SECS < 1) begin : g_param_check
        $error("microwave_timer_ctrl: TICK_DIV must be >= 2 and BEEP_SECS >= 1");
    end

    state_t        state_q, state_d;
    logic [3:0]    m1_q, m0_q, s1_q, s0_q;
    logic [3:0]    m1_d, m0_d, s1_d, s0_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          mag_q, mag_d;
    logic          done_q, done_d;
    logic          count_en;

    logic [3:0]    dec_m1, dec_m0, dec_s1, dec_s0;
    logic          dec_zero;
    logic          digits_nz;

    assign digits_nz = |{m1_q, m0_q, s1_q, s0_q};

    // One-second BCD decrement of the displayed time; 59 reload only on a borrow.
    always_comb begin
        dec_m1 = m1_q;
        dec_m0 = m0_q;
        dec_s1 = s1_q;
        dec_s0 = s0_q - 4'd1;
        if (s0_q == 4'd0) begin
            dec_s0 = 4'd9;
            if (s1_q != 4'd0) begin
                dec_s1 = s1_q - 4'd1;
            end else begin
                dec_s1 = 4'd5;
                if (m0_q != 4'd0) begin
                    dec_m0 = m0_q - 4'd1;
                end else begin
                    dec_m0 = 4'd9;
                    dec_m1 = m1_q - 4'd1;
                end
            end
        end
        dec_zero = ({dec_m1, dec_m0, dec_s1, dec_s0} == 16'h0000);
    end

`ifdef DONE_BEEP_EN
    localparam int BW = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_SECS - 1);
    logic          beep_q, beep_d;
    logic [BW-1:0] beep_cnt_q, beep_cnt_d;
`endif

    // Next-state, digit and prescaler logic; clear > pause > start > digit.
    always_comb begin
        state_d  = state_q;
        m1_d     = m1_q;
        m0_d     = m0_q;
        s1_d     = s1_q;
        s0_d     = s0_q;
        presc_d  = presc_q;
        done_d   = 1'b0;
        count_en = 1'b0;
`ifdef DONE_BEEP_EN
        beep_d     = 1'b0;
        beep_cnt_d = beep_cnt_q;
`endif
        if (clear) begin
            state_d = ST_IDLE;
            m1_d    = 4'd0;
            m0_d    = 4'd0;
            s1_d    = 4'd0;
            s0_d    = 4'd0;
            presc_d = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ENTRY, ST_DONE: begin
                    if (!pause) begin
                        if (start) begin
                            if (state_q != ST_DONE && digits_nz) begin
                                state_d = ST_RUN;
                                presc_d = '0;
                            end
                        end else if (digit_valid && digit_in <= 4'd9) begin
                            // DONE already holds 0000, so the shift starts from zero there.
                            m1_d    = m0_q;
                            m0_d    = s1_q;
                            s1_d    = s0_q;
                            s0_d    = digit_in;
                            state_d = ST_ENTRY;
                        end
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else begin
                        count_en = 1'b1;
                    end
                end
                ST_PAUSED: begin
                    // The resume edge counts as the cycle the pause edge swallowed,
                    // so a pause never stretches or shortens the current second.
                    if (!pause && start) begin
                        state_d  = ST_RUN;
                        count_en = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (count_en) begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    m1_d    = dec_m1;
                    m0_d    = dec_m0;
                    s1_d    = dec_s1;
                    s0_d    = dec_s0;
                    if (dec_zero) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end

`ifdef DONE_BEEP_EN
            // Beep runs for BEEP_SECS prescaler wraps while we stay in DONE.
            if (state_q == ST_DONE && state_d == ST_DONE && beep_q) begin
                beep_d = 1'b1;
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (beep_cnt_q == BEEP_LAST) begin
                        beep_d = 1'b0;
                    end else begin
                        beep_cnt_d = beep_cnt_q + 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            if (state_q != ST_DONE && state_d == ST_DONE) begin
                beep_d     = 1'b1;
                beep_cnt_d = '0;
            end
`endif
        end
        mag_d = (state_d == ST_RUN);
    end

    // State, digit and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            m1_q    <= 4'd0;
            m0_q    <= 4'd0;
            s1_q    <= 4'd0;
            s0_q    <= 4'd0;
            presc_q <= '0;
            mag_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m1_q    <= m1_d;
            m0_q    <= m0_d;
            s1_q    <= s1_d;
            s0_q    <= s0_d;
            presc_q <= presc_d;
            mag_q   <= mag_d;
            done_q  <= done_d;
        end
    end

`ifdef DONE_BEEP_EN
    // Beeper and its seconds counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beep_q     <= 1'b0;
            beep_cnt_q <= '0;
        end else begin
            beep_q     <= beep_d;
            beep_cnt_q <= beep_cnt_d;
        end
    end
    assign beep = beep_q;
`else
    assign beep = 1'b0;
`endif

    assign min_D1       = m1_q;
    assign min_D0       = m0_q;
    assign sec_D1       = s1_q;
    assign sec_D0       = s0_q;
    assign state        = state_q;
    assign magnetron_en = mag_q;
    assign done         = done_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed-vector bench for microwave_timer_ctrl (TICK_DIV=4, BEEP_SECS=2).
module tb_microwave_timer_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int BEEP_SECS = 2;
`ifdef DONE_BEEP_EN
    localparam logic BEEP_ON = 1'b1;
`else
    localparam logic BEEP_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       digit_valid = 1'b0;
    logic [3:0] digit_in = 4'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] min_D1, min_D0, sec_D1, sec_D0;
    logic [2:0] state;
    logic       magnetron_en, done, beep;

    int vec_cnt = 0;
    int err_cnt = 0;

    wire [15:0] disp = {min_D1, min_D0, sec_D1, sec_D0};

    microwave_timer_ctrl #(.TICK_DIV(TICK_DIV), .BEEP_SECS(BEEP_SECS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .digit_valid  (digit_valid),
        .digit_in     (digit_in),
        .start        (start),
        .pause        (pause),
        .clear        (clear),
        .min_D1       (min_D1),
        .min_D0       (min_D0),
        .sec_D1       (sec_D1),
        .sec_D0       (sec_D0),
        .state        (state),
        .magnetron_en (magnetron_en),
        .done         (done),
        .beep         (beep)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("vec %0d %s ok (%h)", vec_cnt, tag, got);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic key(input logic [3:0] d);
        digit_valid = 1'b1;
        digit_in    = d;
        step(1);
        digit_valid = 1'b0;
        digit_in    = 4'd0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic do_pause();
        pause = 1'b1;
        step(1);
        pause = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    initial begin
        // Reset state
        step(2);
        check("rst_digits", disp, 16'h0000);
        check("rst_state", 16'(state), 16'd0);
        check("rst_mag", 16'(magnetron_en), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_beep", 16'(beep), 16'd0);
        rst_n = 1'b1;

        // 1: keypad entry and invalid digit
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
        check("entry_digits", disp, 16'h2345);
        check("entry_state", 16'(state), 16'd1);
        key(4'hB);
        check("bad_key_digits", disp, 16'h2345);
        check("bad_key_state", 16'(state), 16'd1);

        // 2: 01:00 countdown with minute borrow
        do_clear();
        check("clear_digits", disp, 16'h0000);
        check("clear_state", 16'(state), 16'd0);
        key(4'd1); key(4'd0); key(4'd0);
        check("t2_digits", disp, 16'h0100);
        do_start();
        check("t2_run_state", 16'(state), 16'd2);
        check("t2_mag", 16'(magnetron_en), 16'd1);
        step(3);
        check("t2_pre_tick", disp, 16'h0100);
        step(1);
        check("t2_tick1", disp, 16'h0059);
        step(4);
        check("t2_tick2", disp, 16'h0058);

        // 3: count to zero, done pulse, beep
        do_clear();
        key(4'd2);
        do_start();
        check("t3_start", disp, 16'h0002);
        step(4);
        check("t3_tick1", disp, 16'h0001);
        step(3);
        check("t3_pre_done", 16'(done), 16'd0);
        step(1);
        check("t3_zero", disp, 16'h0000);
        check("t3_state_done", 16'(state), 16'd4);
        check("t3_done_pulse", 16'(done), 16'd1);
        check("t3_mag_off", 16'(magnetron_en), 16'd0);
        check("t3_beep_on", 16'(beep), 16'(BEEP_ON));
        step(1);
        check("t3_done_once", 16'(done), 16'd0);
        step(6);
        check("t3_beep_last", 16'(beep), 16'(BEEP_ON));
        step(1);
        check("t3_beep_off", 16'(beep), 16'd0);
        check("t3_hold_zero", disp, 16'h0000);
        key(4'd7);
        check("t3_done_key", disp, 16'h0007);
        check("t3_done_key_state", 16'(state), 16'd1);

        // 4: pause and resume
        do_clear();
        key(4'd5);
        do_start();
        step(4);
        check("t4_tick1", disp, 16'h0004);
        step(1);
        do_pause();
        check("t4_paused", 16'(state), 16'd3);
        check("t4_paused_mag", 16'(magnetron_en), 16'd0);
        step(20);
        check("t4_frozen", disp, 16'h0004);
        do_start();
        check("t4_resume_state", 16'(state), 16'd2);
        step(1);
        check("t4_resume_hold", disp, 16'h0004);
        step(1);
        check("t4_resume_tick", disp, 16'h0003);

        // 5: start with zero, clear beats start, pause beats tick, 00:90
        do_clear();
        do_start();
        check("t5_zero_start", 16'(state), 16'd0);
        check("t5_zero_mag", 16'(magnetron_en), 16'd0);
        key(4'd3);
        do_start();
        step(2);
        clear = 1'b1;
        start = 1'b1;
        step(1);
        clear = 1'b0;
        start = 1'b0;
        check("t5_clr_start_state", 16'(state), 16'd0);
        check("t5_clr_start_digits", disp, 16'h0000);
        check("t5_clr_start_mag", 16'(magnetron_en), 16'd0);
        key(4'd3);
        do_start();
        step(3);
        do_pause();
        check("t5_pause_tick_digits", disp, 16'h0003);
        check("t5_pause_tick_state", 16'(state), 16'd3);
        do_start();
        check("t5_resume_wrap", disp, 16'h0002);
        do_clear();
        key(4'd9); key(4'd0);
        do_start();
        step(4);
        check("t5_90_tick", disp, 16'h0089);
        do_clear();

        // 6: asynchronous reset mid-run
        key(4'd1); key(4'd0);
        do_start();
        step(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_mag", 16'(magnetron_en), 16'd0);
        check("t6_rst_state", 16'(state), 16'd0);
        check("t6_rst_digits", disp, 16'h0000);
        step(1);
        rst_n = 1'b1;
        key(4'd4);
        do_start();
        check("t6_restart_mag", 16'(magnetron_en), 16'd1);
        step(4);
        check("t6_restart_tick", disp, 16'h0003);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
